// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package mips_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] inst;
    } fifo_entry_t;

    // Force a fetch target onto a word boundary.
    function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] pc);
        return {pc[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of {pc, inst} entries; clear overrides push and pop.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  fifo_entry_t   entry_i,
    output fifo_entry_t   entry_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    fifo_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~clear_i & ~empty_o;
    assign do_push = push_i & ~clear_i & (~full_o | pop_i);

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign entry_o = mem_q[rd_ptr_q];

    // Entry storage; reset to zero so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding memory read at a time, results buffered with their PC.
module instr_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                 DEPTH    = 4,
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [INSTR_W-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               inst_valid,
    output logic [INSTR_W-1:0] inst,
    output logic [INSTR_W-1:0] inst_pc,
    input  logic               inst_ready,
    input  logic               redirect,
    input  logic [INSTR_W-1:0] redirect_pc
);

    localparam int CW  = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;
    localparam int CNW = CW + 1;

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [INSTR_W-1:0] mem_addr_q, mem_addr_d;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CW-1:0]      fifo_count;
    logic [CNW-1:0]     cnt_after_push;
    fifo_entry_t        push_entry;
    fifo_entry_t        head_entry;

    assign pop            = ~fifo_empty & inst_ready;
    assign push_entry     = {mem_addr_q, mem_rdata};
    assign cnt_after_push = {1'b0, fifo_count} + CNW'(1) - CNW'(pop);

    assign mem_req    = (state_q == WAIT);
    assign mem_addr   = mem_addr_q;
    assign inst_valid = ~fifo_empty;
    assign inst       = head_entry.inst;
    assign inst_pc    = head_entry.pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (redirect),
        .entry_i (push_entry),
        .entry_o (head_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Next-state logic: redirect wins; otherwise request whenever a FIFO slot stays free.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        if (redirect) begin
            fetch_pc_d = align_pc(redirect_pc);
            unique case (state_q)
                IDLE:    state_d = IDLE;
                WAIT:    state_d = mem_ack ? IDLE : DROP;
                // An ack landing together with a redirect is the owed one, so DROP is done.
                DROP:    state_d = mem_ack ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    // With no push in IDLE, count_next < DEPTH reduces to "not full, or popping".
                    if (!fifo_full || pop) begin
                        mem_addr_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + INSTR_W'(PC_INC);
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        push = 1'b1;
                        if (cnt_after_push < CNW'(DEPTH)) begin
                            mem_addr_d = fetch_pc_q;
                            fetch_pc_d = fetch_pc_q + INSTR_W'(PC_INC);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (mem_ack) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, fetch PC and request address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage placed directly upstream of the single-cycle MIPS datapath/controller pair. It issues word reads to a variable-latency instruction memory over a req/ack handshake and buffers the returned instructions, each tagged with its PC, in a small FIFO. The core pulls instructions through a valid/ready interface. On a taken branch or jump, the core redirects the fetch stream: buffered and in-flight instructions are discarded and fetching restarts at the new PC.

## Interface
- DEPTH, 4 — FIFO entries, power of two, minimum 2.
- RESET_PC, 32'h0000_0000 — first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — asynchronous, active-low reset.
- mem_req  out  1  — read request to instruction memory.
- mem_addr  out  32  — word-aligned read address; held stable while mem_req=1 and no ack.
- mem_ack  in  1  — one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  — instruction word.
- inst_valid  out  1  — FIFO head is valid.
- inst  out  32  — head instruction.
- inst_pc  out  32  — PC of the head instruction.
- inst_ready  in  1  — core consumes the head on valid&ready.
- redirect  in  1  — one-cycle flush request with a new fetch target.
- redirect_pc  in  32  — new fetch target; bits [1:0] are ignored and treated as 0.

## Operation
- Registers:
  - fetch_pc, the next address to request.
  - FIFO of {pc, inst} with a count from 0 to DEPTH.
  - FSM state: IDLE, WAIT, DROP.
- At most one request is outstanding at any time. mem_req=1 exactly in state WAIT.
- IDLE:
  - If count_next < DEPTH and no redirect, set mem_addr<=fetch_pc and fetch_pc<=fetch_pc+4, then go to WAIT.
  - count_next is the count after this cycle's push and pop.
- WAIT, with mem_ack=1 and no redirect:
  - Push {mem_addr, mem_rdata}.
  - If count_next < DEPTH after that push, issue the next request back-to-back: mem_addr<=fetch_pc, fetch_pc+=4, stay in WAIT.
  - Otherwise go to IDLE.
- WAIT, with mem_ack=0: hold mem_addr and stay in WAIT.
- Redirect, which has priority over every other event:
  - The FIFO is cleared: count<=0, and a same-cycle pop or push is ignored.
  - fetch_pc<=redirect_pc with bits [1:0] cleared.
  - From WAIT without ack: go to DROP.
  - From WAIT with a same-cycle ack: the returned data is discarded; go to IDLE.
  - From IDLE: stay in IDLE.
  - From DROP: update fetch_pc and stay in DROP.
- DROP:
  - mem_req=0; the memory still owes one ack.
  - The ack that arrives in DROP is discarded, then go to IDLE.
  - No new request is issued until that ack is seen.
- FIFO:
  - Pop on inst_valid & inst_ready.
  - A simultaneous push and pop when full is legal; the count is unchanged.
  - The pointer width is log2(DEPTH) and wraps naturally.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - mem_req=0, mem_addr=RESET_PC.
  - inst_valid=0, inst=0, inst_pc=0.
  - fetch_pc=RESET_PC, count=0, state=IDLE.
- mem_req first rises in the first clock edge after rst deasserts.
- Latency from mem_ack to inst_valid is 1 cycle; the FIFO is written at the ack edge.
- Zero-wait memory (ack in the cycle after req rises), with the consumer always ready: one instruction per cycle after the first.
- Latency from redirect to new-PC mem_req:
  - 1 cycle from IDLE.
  - Ack arrival +1 cycle from WAIT/DROP.
- inst_valid falls in the cycle after redirect.
- Reset asserted mid-transaction returns every register to its reset value immediately. An ack arriving while reset is asserted is ignored.

## Structure
- Package mips_fetch_pkg holds:
  - INSTR_W=32 and PC_INC=4.
  - The fetch_state_t enum {IDLE, WAIT, DROP}.
  - The fifo_entry_t struct {pc, inst}.
- Sub-module fetch_fifo, parameterised by DEPTH:
  - Ports: push, pop, clear, entry in/out, count, empty, full.
  - Clear overrides push and pop.
- The top level holds the FSM and fetch_pc.

## Test plan
- Reset, RESET_PC=0, memory acks 1 cycle after req, inst_ready=1 → requests to 0,4,8,…; the inst_pc sequence matches; one instruction per cycle in steady state.
- inst_ready=0 with DEPTH=4 → exactly 4 acks accepted, then mem_req=0; raise ready for 1 cycle → exactly one new request issues.
- Redirect to 32'h0000_0103 while in WAIT with ack delayed 3 cycles → the late ack's data never appears on inst; the next mem_addr is 32'h0000_0100.
- Redirect in the same cycle as mem_ack → the acked data is dropped and no DROP state is entered; the next request goes to the redirect target in the following cycle.
- fetch_pc at 32'hFFFF_FFFC → the next mem_addr is 32'h0000_0000.
- Assert rst for 1 cycle while FIFO holds 3 entries and WAIT is pending → inst_valid=0 and mem_req=0 immediately; the fetch restarts at RESET_PC.
